// File: rtl/eq_vector_driver_pkg.sv
// Shared types for the equality-comparator sweep driver.
// State encodings are fixed so the debug output decodes the same on every build.
package eq_vector_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Width of the dwell counter for a given settle time (holds SETTLE_CYCLES-1).
  function automatic int dwell_width(input int settle_cycles);
    return $clog2(settle_cycles) + 1;
  endfunction

endpackage

// File: rtl/eq_vector_driver_dwell_timer.sv
// Loadable down-counter that paces how long each vector is held before sampling.
// Load has priority; the count stops at zero until reloaded.
module eq_dwell_timer #(
  parameter int TW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          zero
);

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/eq_vector_driver.sv
// Drives every {a,b} pair into an equality comparator, checks eq_in against a==b,
// counts mismatches and captures the first failing vector.
module eq_vector_driver
  import eq_vector_driver_pkg::*;
#(
  parameter int WIDTH         = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               eq_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b,
  output state_t             state_dbg
);

  localparam int VW = 2 * WIDTH;
  localparam int EW = 2 * WIDTH + 1;
  localparam int TW = dwell_width(SETTLE_CYCLES);
  localparam logic [VW-1:0] V_LAST     = '1;
  localparam logic [TW-1:0] DWELL_INIT = TW'(SETTLE_CYCLES - 1);

  state_t          state_q, state_d;
  logic [VW-1:0]   v_q, v_d;
  logic [EW-1:0]   err_q, err_d;
  logic            fail_valid_q, fail_valid_d;
  logic [WIDTH-1:0] fail_a_q, fail_a_d;
  logic [WIDTH-1:0] fail_b_q, fail_b_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic            dwell_load;
  logic            dwell_zero;
  logic            mismatch;

  eq_dwell_timer #(.TW(TW)) u_dwell (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (dwell_load),
    .value   (DWELL_INIT),
    .zero    (dwell_zero)
  );

  assign mismatch = eq_in ^ (v_q[VW-1:WIDTH] == v_q[WIDTH-1:0]);

  always_comb begin
    state_d      = state_q;
    v_d          = v_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_a_d     = fail_a_q;
    fail_b_d     = fail_b_q;
    busy_d       = busy_q;
    done_d       = done_q;
    pass_d       = pass_q;
    dwell_load   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_DRIVE;
          v_d          = '0;
          dwell_load   = 1'b1;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_a_d     = '0;
          fail_b_d     = '0;
          busy_d       = 1'b1;
          done_d       = 1'b0;
          pass_d       = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (dwell_zero) begin
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_a_d     = v_q[VW-1:WIDTH];
            fail_b_d     = v_q[WIDTH-1:0];
          end
        end
        if (v_q == V_LAST) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // Uses the post-update count so a mismatch on the final vector is seen.
          pass_d  = (err_d == '0);
        end else begin
          state_d    = ST_DRIVE;
          v_d        = v_q + 1'b1;
          dwell_load = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      v_q          <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_a_q     <= '0;
      fail_b_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      v_q          <= v_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_a_q     <= fail_a_d;
      fail_b_q     <= fail_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign a_out      = v_q[VW-1:WIDTH];
  assign b_out      = v_q[WIDTH-1:0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_a     = fail_a_q;
  assign fail_b     = fail_b_q;
  assign state_dbg  = state_q;

endmodule
